simd_data_mover: RTL and testbench
==================================

// Module: simd_data_mover
// PURPOSE
// - Parametrised BRAM<->PE data mover for the SIMD array; successor of the fixed 4-PE, 2-cycle-latency fetch unit.
// - Executes one LOAD or STORE command at a time over a single BRAM port B, with fully pipelined issue (1 word/cycle).
// - LOAD delivers words to a PE subset chosen by mask; STORE writes PE results back.
// - Sits between the control unit (command handshake) and the PE array / data BRAM.
// PARAMETERS
// - NUM_PE   4   number of processing elements (>=1)
// - DATA_W   32  word width (multiple of 8)
// - ADDR_W   13  BRAM word-address width
// - LEN_W    5   command length width; max burst = 2**LEN_W-1 words
// - RD_LAT   2   BRAM read latency in cycles (>=1)
// PORTS
// - CLK           in   1               clock
// - RSTN          in   1               asynchronous active-low reset
// - CMD_VALID     in   1               command request
// - CMD_READY     out  1               high only in IDLE; accept when CMD_VALID&CMD_READY
// - CMD_OP        in   1               0=LOAD, 1=STORE
// - CMD_BASE      in   ADDR_W          first BRAM address
// - CMD_LEN       in   LEN_W           word count
// - CMD_PE_MASK   in   NUM_PE          LOAD destination PEs (broadcast to every set bit)
// - BUSY          out  1               command in progress (not IDLE)
// - DONE          out  1               1-cycle pulse at command completion
// - addrb         out  ADDR_W          BRAM address
// - dinb          out  DATA_W          BRAM write data
// - doutb         in   DATA_W          BRAM read data
// - enb           out  1               BRAM enable
// - web           out  DATA_W/8        BRAM byte write enables
// - PE_DIN        out  NUM_PE*DATA_W   per-PE load data, PE i at [i*DATA_W +: DATA_W]
// - PE_DIN_VLD    out  NUM_PE          per-PE load strobe
// - PE_DIN_IDX    out  LEN_W           word index of current load beat
// - PE_DOUT       in   NUM_PE*DATA_W   per-PE store data
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, counters=0, DONE=0, enb=0, web=0, addrb=0,
//   PE_DIN_VLD=0, in-flight pipe cleared. Reset mid-command aborts with no DONE; enb drops immediately.
// - FSM: IDLE -> ISSUE on accept (LEN>0); ISSUE -> DRAIN after last word issued (LOAD);
//   ISSUE -> FIN after last write (STORE); DRAIN -> FIN when pipe empty; FIN -> IDLE (DONE=1 in FIN).
// - LEN=0: IDLE -> FIN directly; no BRAM access; DONE at T+1.
// - Command fields latched at accept cycle T; inputs ignored until back in IDLE.
// - Issue counter k=0..LEN-1, addrb=CMD_BASE+k mod 2**ADDR_W (wraps silently), one word per cycle from T+1.
// - LOAD: enb=1, web=0 in cycles T+1..T+LEN; word k on doutb at T+1+k+RD_LAT.
//   In that cycle PE_DIN[i]=doutb and PE_DIN_VLD[i]=1 for each mask bit set; unmasked PEs get 0/0.
//   PE_DIN_IDX=k. DONE at T+LEN+RD_LAT+1. Mask=0: reads still performed, no strobes.
// - STORE: enb=1, web=all-ones in T+1..T+LEN, dinb=PE_DOUT[k mod NUM_PE] (sampled combinationally). DONE at T+LEN+1.
// - Outside active issue cycles: enb=0, web=0, dinb=0, addrb holds last value.
// - In-flight tracking: RD_LAT-deep valid+index shift register; never stalls, no backpressure from PEs.
// - CMD_VALID high during FIN is not accepted (CMD_READY=0); earliest back-to-back accept at DONE+1.
// STRUCTURE
// - Package simd_data_mover_pkg: op_e {OP_LOAD,OP_STORE}, state_e {IDLE,ISSUE,DRAIN,FIN}.
// - One sub-module: rd_latency_pipe (params RD_LAT, LEN_W): shift register of {valid, idx}.
// - Top holds FSM, issue counter, address adder, PE routing/mux.
// TESTING
// - Reset then LOAD base=0x10 len=4 mask=4'b1111, RD_LAT=2: reads 0x10..0x13 at T+1..T+4;
//   all PE_DIN_VLD high T+3..T+6 with idx 0..3; DONE at T+7.
// - LOAD len=3 mask=4'b0100: only PE_DIN_VLD[2] pulses; PE_DIN[0,1,3]=0 throughout.
// - STORE base=0x1FFE len=4 (ADDR_W=13): addrb 0x1FFE,0x1FFF,0x0000,0x0001; dinb=PE_DOUT[0..3]; DONE T+5.
// - LEN=0 LOAD: no enb; DONE at T+1; CMD_READY back high at T+2.
// - RSTN low at T+2 of len=8 LOAD: enb, PE_DIN_VLD, BUSY drop same cycle; no DONE; next command runs normally.
// - Param sweep NUM_PE=8, RD_LAT=1/3, LEN=31 back-to-back LOAD/STORE: scoreboard vs. BRAM model, DONE timing per formula.

Source files
------------

// File: rtl/simd_data_mover_pkg.sv
// Shared types for the SIMD BRAM<->PE data mover.
// Command opcodes and controller states.
package simd_data_mover_pkg;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/simd_data_mover_rd_latency_pipe.sv
// In-flight read tracker: RD_LAT-deep shift register of {valid, idx}.
// Never stalls; the last stage lines up with BRAM read data.
module rd_latency_pipe #(
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 5
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             in_vld,
  input  logic [LEN_W-1:0] in_idx,
  output logic             out_vld,
  output logic [LEN_W-1:0] out_idx,
  output logic             drained
);

  logic [RD_LAT-1:0] vld_q;
  logic [LEN_W-1:0]  idx_q [RD_LAT];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_idx = idx_q[RD_LAT-1];

  // High when only the output stage can still hold a beat
  generate
    if (RD_LAT > 1) begin : g_deep
      assign drained = !in_vld && !(|vld_q[RD_LAT-2:0]);
    end else begin : g_one
      assign drained = !in_vld;
    end
  endgenerate

endmodule

// File: rtl/simd_data_mover.sv
// Parametrised BRAM<->PE data mover: one LOAD/STORE burst at a time,
// one word per cycle over BRAM port B.
module simd_data_mover
  import simd_data_mover_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 5,
  parameter int RD_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic                     CMD_OP,
  input  logic [ADDR_W-1:0]        CMD_BASE,
  input  logic [LEN_W-1:0]         CMD_LEN,
  input  logic [NUM_PE-1:0]        CMD_PE_MASK,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [ADDR_W-1:0]        addrb,
  output logic [DATA_W-1:0]        dinb,
  input  logic [DATA_W-1:0]        doutb,
  output logic                     enb,
  output logic [DATA_W/8-1:0]      web,
  output logic [NUM_PE*DATA_W-1:0] PE_DIN,
  output logic [NUM_PE-1:0]        PE_DIN_VLD,
  output logic [LEN_W-1:0]         PE_DIN_IDX,
  input  logic [NUM_PE*DATA_W-1:0] PE_DOUT
);

  localparam int SEL_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  state_e              state;
  op_e                 op_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    k_q;
  logic [NUM_PE-1:0]   mask_q;
  logic [SEL_W-1:0]    sel_q;
  logic                last_k;
  logic                rd_issue;
  logic                pipe_vld;
  logic [LEN_W-1:0]    pipe_idx;
  logic                pipe_drained;

  assign last_k   = (k_q == len_q - LEN_W'(1));
  assign rd_issue = enb && !web[0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      op_q      <= OP_LOAD;
      len_q     <= '0;
      k_q       <= '0;
      mask_q    <= '0;
      sel_q     <= '0;
      addrb     <= '0;
      enb       <= 1'b0;
      web       <= '0;
      CMD_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CMD_VALID) begin
            op_q      <= op_e'(CMD_OP);
            len_q     <= CMD_LEN;
            mask_q    <= CMD_PE_MASK;
            k_q       <= '0;
            sel_q     <= '0;
            addrb     <= CMD_BASE;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            if (CMD_LEN == '0) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else begin
              state <= ISSUE;
              enb   <= 1'b1;
              web   <= {(DATA_W/8){CMD_OP}};
            end
          end
        end
        ISSUE: begin
          if (last_k) begin
            enb <= 1'b0;
            web <= '0;
            if (op_q == OP_STORE) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            k_q   <= k_q + LEN_W'(1);
            addrb <= addrb + ADDR_W'(1);
            // PE select tracks k mod NUM_PE without a divider
            if (sel_q == SEL_W'(NUM_PE - 1)) sel_q <= '0;
            else sel_q <= sel_q + SEL_W'(1);
          end
        end
        DRAIN: begin
          if (pipe_drained) begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
        FIN: begin
          state     <= IDLE;
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_latency_pipe #(
    .RD_LAT (RD_LAT),
    .LEN_W  (LEN_W)
  ) u_pipe (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .in_vld  (rd_issue),
    .in_idx  (k_q),
    .out_vld (pipe_vld),
    .out_idx (pipe_idx),
    .drained (pipe_drained)
  );

  always_comb begin
    dinb = '0;
    if (web[0]) dinb = PE_DOUT[int'(sel_q)*DATA_W +: DATA_W];
  end

  always_comb begin
    PE_DIN     = '0;
    PE_DIN_VLD = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (pipe_vld && mask_q[i]) begin
        PE_DIN_VLD[i]                = 1'b1;
        PE_DIN[i*DATA_W +: DATA_W]   = doutb;
      end
    end
  end

  assign PE_DIN_IDX = pipe_idx;

endmodule

// File: tb/tb_simd_data_mover.sv
// Scoreboard bench for simd_data_mover with a behavioural BRAM model.
// PE_DOUT is a known function of the cycle number.
module tb_simd_data_mover;
  localparam int NUM_PE = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 5;
  localparam int RD_LAT = 2;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     CLK;
  logic                     RSTN;
  logic                     CMD_VALID;
  logic                     CMD_READY;
  logic                     CMD_OP;
  logic [ADDR_W-1:0]        CMD_BASE;
  logic [LEN_W-1:0]         CMD_LEN;
  logic [NUM_PE-1:0]        CMD_PE_MASK;
  logic                     BUSY;
  logic                     DONE;
  logic [ADDR_W-1:0]        addrb;
  logic [DATA_W-1:0]        dinb;
  logic [DATA_W-1:0]        doutb;
  logic                     enb;
  logic [BE_W-1:0]          web;
  logic [NUM_PE*DATA_W-1:0] PE_DIN;
  logic [NUM_PE-1:0]        PE_DIN_VLD;
  logic [LEN_W-1:0]         PE_DIN_IDX;
  logic [NUM_PE*DATA_W-1:0] PE_DOUT;

  simd_data_mover #(
    .NUM_PE (NUM_PE),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_OP      (CMD_OP),
    .CMD_BASE    (CMD_BASE),
    .CMD_LEN     (CMD_LEN),
    .CMD_PE_MASK (CMD_PE_MASK),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .addrb       (addrb),
    .dinb        (dinb),
    .doutb       (doutb),
    .enb         (enb),
    .web         (web),
    .PE_DIN      (PE_DIN),
    .PE_DIN_VLD  (PE_DIN_VLD),
    .PE_DIN_IDX  (PE_DIN_IDX),
    .PE_DOUT     (PE_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pe_val(input int c, input int i);
    logic [15:0] cl;
    logic [7:0]  il;
    cl = c[15:0];
    il = i[7:0];
    return {cl, il, 8'hC3};
  endfunction

  // BRAM model: RD_LAT-cycle registered read, byte writes all-or-nothing
  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DATA_W-1:0] rd_p   [RD_LAT];

  always @(posedge CLK) begin
    if (enb && web == {BE_W{1'b1}}) mem[addrb] <= dinb;
    rd_p[0] <= mem[addrb];
    for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
  end
  assign doutb = rd_p[RD_LAT-1];

  always @(posedge CLK) begin
    cyc++;
    #1;
    for (int i = 0; i < NUM_PE; i++)
      PE_DOUT[i*DATA_W +: DATA_W] = pe_val(cyc, i);
  end

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } iss_t;

  typedef struct {
    int                cyc;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [NUM_PE-1:0] mask;
  } beat_t;

  iss_t  iss_q  [$];
  beat_t beat_q [$];
  int    done_q [$];

  iss_t  ie;
  beat_t be;
  int    dexp;
  logic [NUM_PE*DATA_W-1:0] exp_din;

  always @(negedge CLK) begin
    if (RSTN && mon_en) begin
      if (enb) begin
        if (iss_q.size() == 0) chk("enb_unexp", enb, 0);
        else begin
          ie = iss_q.pop_front();
          chk("iss_cyc", cyc, ie.cyc);
          chk("addrb", addrb, ie.addr);
          chk("web", web, {BE_W{ie.we}});
          if (ie.we) chk("dinb", dinb, ie.data);
        end
      end else begin
        chk("bram_idle", {web, dinb}, 0);
      end
      if (|PE_DIN_VLD) begin
        if (beat_q.size() == 0) chk("vld_unexp", PE_DIN_VLD, 0);
        else begin
          be = beat_q.pop_front();
          exp_din = '0;
          for (int i = 0; i < NUM_PE; i++)
            if (be.mask[i]) exp_din[i*DATA_W +: DATA_W] = be.data;
          chk("beat_cyc", cyc, be.cyc);
          chk("pe_vld", PE_DIN_VLD, be.mask);
          chk("pe_idx", PE_DIN_IDX, be.idx);
          chk("pe_din", PE_DIN, exp_din);
        end
      end else begin
        chk("pe_din_idle", PE_DIN, 0);
      end
      if (DONE) begin
        if (done_q.size() == 0) chk("done_unexp", DONE, 0);
        else begin
          dexp = done_q.pop_front();
          chk("done_cyc", cyc, dexp);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after acceptance
  task automatic send(input bit op, input int base, input int len,
                      input logic [NUM_PE-1:0] mask);
    int t;
    int n;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    CMD_VALID   = 1'b1;
    CMD_OP      = op;
    CMD_BASE    = base[ADDR_W-1:0];
    CMD_LEN     = len[LEN_W-1:0];
    CMD_PE_MASK = mask;
    n = 0;
    while (!CMD_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) begin
      chk("ready_timeout", CMD_READY, 1);
      CMD_VALID = 1'b0;
      return;
    end
    t = cyc;
    for (int k = 0; k < len; k++) begin
      a = ADDR_W'(base + k);
      if (op) begin
        d = pe_val(t + 1 + k, k % NUM_PE);
        shadow[a] = d;
        iss_q.push_back('{t + 1 + k, a, 1'b1, d});
      end else begin
        iss_q.push_back('{t + 1 + k, a, 1'b0, '0});
        if (mask != '0)
          beat_q.push_back('{t + 1 + k + RD_LAT, LEN_W'(k), shadow[a], mask});
      end
    end
    if (len == 0) done_q.push_back(t + 1);
    else if (op) done_q.push_back(t + len + 1);
    else done_q.push_back(t + len + RD_LAT + 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY || done_q.size() != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) chk("idle_timeout", BUSY, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = (i * 32'h9E37) ^ 32'h1234_0000;
      shadow[i] = (i * 32'h9E37) ^ 32'h1234_0000;
    end
    RSTN        = 1'b0;
    CMD_VALID   = 1'b0;
    CMD_OP      = 1'b0;
    CMD_BASE    = '0;
    CMD_LEN     = '0;
    CMD_PE_MASK = '0;
    PE_DOUT     = '0;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_enb", enb, 0);
    chk("rst_web", web, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_vld", PE_DIN_VLD, 0);
    mon_en = 1'b1;

    send(0, 'h10, 4, 4'b1111);
    wait_idle();
    send(0, 'h20, 3, 4'b0100);
    wait_idle();
    send(1, 'h1FFE, 4, 4'b0000);
    wait_idle();
    send(0, 'h1FFE, 4, 4'b1010);
    wait_idle();

    send(0, 'h40, 0, 4'b1111);
    @(negedge CLK);
    chk("len0_ready", CMD_READY, 1);
    wait_idle();

    send(0, 'h50, 5, 4'b0000);
    wait_idle();

    // Abort a long load two cycles after acceptance
    send(0, 'h100, 8, 4'b1111);
    @(posedge CLK);
    #1 RSTN = 1'b0;
    #1;
    chk("abort_enb", enb, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_vld", PE_DIN_VLD, 0);
    chk("abort_done", DONE, 0);
    iss_q.delete();
    beat_q.delete();
    done_q.delete();
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b1;
    @(negedge CLK);
    send(0, 'h100, 8, 4'b0011);
    wait_idle();

    // Back-to-back max-length bursts, each load reading the prior store
    for (int j = 0; j < 4; j++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      send(1, b, 31, 4'b0000);
      send(0, b, 31, 4'($urandom_range(1, 15)));
    end
    wait_idle();
    repeat (RD_LAT + 2) @(negedge CLK);

    chk("iss_left", iss_q.size(), 0);
    chk("beat_left", beat_q.size(), 0);
    chk("done_left", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
